// File: rtl/br_exec_pipe.sv
// rtl/br_exec_pipe.sv - pipelined branch/jump resolve unit with result FIFO and perf counters
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               issue handshake from the branch reservation station
//   in_opcode, in_funct3, in_rob    instruction class, compare op, ROB tag
//   in_pc, in_imm, in_rs1, in_rs2   operands
//   in_pred_taken, in_pred_target   front-end prediction to check against
//   flush                           synchronous pipeline flush (empties the FIFO)
//   out_valid/out_ready             writeback handshake for the FIFO head
//   out_rob .. out_mispredict       resolved result at the FIFO head
//   cnt_resolved, cnt_mispred       saturating performance counters
module br_exec_pipe #(
  parameter int ROB_W = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [ROB_W-1:0] in_rob,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic             in_pred_taken,
  input  logic [31:0]      in_pred_target,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROB_W-1:0] out_rob,
  output logic [31:0]      out_rd_data,
  output logic             out_taken,
  output logic [31:0]      out_target,
  output logic [31:0]      out_next_pc,
  output logic             out_mispredict,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_mispred
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);
  localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(DEPTH);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic [31:0]      rd_data;
    logic [31:0]      target;
    logic [31:0]      next_pc;
    logic             taken;
    logic             mispredict;
    logic             is_ctl;     // JAL/JALR/BR; only these are counted
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic [CNT_W-1:0]  res_q, res_d;
  logic [CNT_W-1:0]  mis_q, mis_d;

  entry_t res_ent;
  logic   push, pop;

  // Resolution of the incoming beat
  always_comb begin
    logic [31:0] pc4, pc_imm, jalr_t;
    logic        br_taken;
    pc4      = in_pc + 32'd4;
    pc_imm   = in_pc + in_imm;
    jalr_t   = (in_rs1 + in_imm) & 32'hFFFF_FFFE;
    case (in_funct3)
      3'b000:  br_taken = (in_rs1 == in_rs2);
      3'b001:  br_taken = (in_rs1 != in_rs2);
      3'b100:  br_taken = ($signed(in_rs1) < $signed(in_rs2));
      3'b101:  br_taken = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110:  br_taken = (in_rs1 < in_rs2);
      3'b111:  br_taken = (in_rs1 >= in_rs2);
      default: br_taken = 1'b0;
    endcase

    res_ent     = '0;
    res_ent.rob = in_rob;
    case (in_opcode)
      OP_JAL: begin
        res_ent.is_ctl  = 1'b1;
        res_ent.taken   = 1'b1;
        res_ent.target  = pc_imm;
        res_ent.rd_data = pc4;
      end
      OP_JALR: begin
        res_ent.is_ctl  = 1'b1;
        res_ent.taken   = 1'b1;
        res_ent.target  = jalr_t;
        res_ent.rd_data = pc4;
      end
      OP_BR: begin
        res_ent.is_ctl  = 1'b1;
        res_ent.taken   = br_taken;
        res_ent.target  = pc_imm;
      end
      default: ;
    endcase

    // Non-control opcodes leave next_pc and mispredict at zero
    if (res_ent.is_ctl) begin
      res_ent.next_pc    = res_ent.taken ? res_ent.target : pc4;
      res_ent.mispredict = (res_ent.taken != in_pred_taken) |
                           (res_ent.taken & (res_ent.target != in_pred_target));
    end
  end

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign out_rob        = mem_q[rd_ptr_q].rob;
  assign out_rd_data    = mem_q[rd_ptr_q].rd_data;
  assign out_taken      = mem_q[rd_ptr_q].taken;
  assign out_target     = mem_q[rd_ptr_q].target;
  assign out_next_pc    = mem_q[rd_ptr_q].next_pc;
  assign out_mispredict = mem_q[rd_ptr_q].mispredict;
  assign cnt_resolved   = res_q;
  assign cnt_mispred    = mis_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    res_d    = res_q;
    mis_d    = mis_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_FW'(push) - CNT_FW'(pop);
    end

    // A pop concurrent with flush still counts: the consumer took the head
    if (pop && mem_q[rd_ptr_q].is_ctl) begin
      if (res_q != '1) res_d = res_q + CNT_W'(1);
      if (mem_q[rd_ptr_q].mispredict && (mis_q != '1)) mis_d = mis_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      res_q    <= '0;
      mis_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      res_q    <= res_d;
      mis_q    <= mis_d;
      if (push) mem_q[wr_ptr_q] <= res_ent;
    end
  end

endmodule

// File: tb/tb_br_exec_pipe.sv
// tb/tb_br_exec_pipe.sv - directed self-checking bench for br_exec_pipe (DEPTH=4, CNT_W=4)
module tb_br_exec_pipe;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rob;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2;
  logic        in_pred_taken;
  logic [31:0] in_pred_target;
  logic        flush;
  logic        out_valid, out_ready;
  logic [4:0]  out_rob;
  logic [31:0] out_rd_data, out_target, out_next_pc;
  logic        out_taken, out_mispredict;
  logic [3:0]  cnt_resolved, cnt_mispred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  br_exec_pipe #(.ROB_W(5), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rob(in_rob),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rob(out_rob), .out_rd_data(out_rd_data), .out_taken(out_taken),
    .out_target(out_target), .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
    .cnt_resolved(cnt_resolved), .cnt_mispred(cnt_mispred)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_beat(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rob,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic pt, input logic [31:0] ptg);
    in_valid       = 1'b1;
    in_opcode      = op;
    in_funct3      = f3;
    in_rob         = rob;
    in_pc          = pc;
    in_imm         = imm;
    in_rs1         = rs1;
    in_rs2         = rs2;
    in_pred_taken  = pt;
    in_pred_target = ptg;
  endtask

  task automatic chk_head(input string tag, input logic [4:0] rob, input logic [31:0] rd,
                          input logic tk, input logic [31:0] tgt, input logic [31:0] npc,
                          input logic mis);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".rob"}, 64'(out_rob), 64'(rob));
    chk({tag, ".rd"}, 64'(out_rd_data), 64'(rd));
    chk({tag, ".taken"}, 64'(out_taken), 64'(tk));
    chk({tag, ".target"}, 64'(out_target), 64'(tgt));
    chk({tag, ".next_pc"}, 64'(out_next_pc), 64'(npc));
    chk({tag, ".mispred"}, 64'(out_mispredict), 64'(mis));
  endtask

  // Push one beat with writeback stalled, then pop it
  task automatic push_one;
    out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic pop_one;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  logic [2:0]  cmp_f3  [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b001};
  logic        cmp_tk  [6] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    set_beat(7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    in_valid = 1'b0;
    #13;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.target", 64'(out_target), 64'd0);
    chk("rst.cnt_res", 64'(cnt_resolved), 64'd0);
    chk("rst.cnt_mis", 64'(cnt_mispred), 64'd0);
    rst_n = 1'b1;
    tick;

    // JAL
    set_beat(OP_JAL, 3'd0, 5'd1, 32'h100, 32'h20, 32'd0, 32'd0, 1'b1, 32'h120);
    push_one;
    chk_head("jal", 5'd1, 32'h104, 1'b1, 32'h120, 32'h120, 1'b0);
    pop_one;
    chk("jal.empty", 64'(out_valid), 64'd0);
    chk("jal.cnt_res", 64'(cnt_resolved), 64'd1);
    chk("jal.cnt_mis", 64'(cnt_mispred), 64'd0);

    // JALR clears bit 0
    set_beat(OP_JALR, 3'd0, 5'd2, 32'h200, 32'h4, 32'h1001, 32'd0, 1'b1, 32'h1004);
    push_one;
    chk_head("jalr", 5'd2, 32'h204, 1'b1, 32'h1004, 32'h1004, 1'b0);
    pop_one;

    // Six compares, rs1=-1, rs2=1, predicted not-taken
    for (int i = 0; i < 6; i++) begin
      set_beat(OP_BR, cmp_f3[i], 5'(3 + i), 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0);
      push_one;
      chk_head($sformatf("br%0d", i), 5'(3 + i), 32'h0, cmp_tk[i], 32'h340,
               cmp_tk[i] ? 32'h340 : 32'h304, cmp_tk[i]);
      pop_one;
    end
    chk("cmp.cnt_res", 64'(cnt_resolved), 64'd8);
    chk("cmp.cnt_mis", 64'(cnt_mispred), 64'd3);

    // Non-control opcode: only rob kept, not counted
    set_beat(OP_ALU, 3'b000, 5'd9, 32'h500, 32'h8, 32'h1, 32'h1, 1'b1, 32'h123);
    push_one;
    chk_head("alu", 5'd9, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    pop_one;
    chk("alu.cnt_res", 64'(cnt_resolved), 64'd8);

    // pc wrap: pc+4 = 0
    set_beat(OP_JAL, 3'd0, 5'd10, 32'hFFFF_FFFC, 32'h8, 32'd0, 32'd0, 1'b1, 32'h4);
    push_one;
    chk_head("wrap", 5'd10, 32'h0, 1'b1, 32'h4, 32'h4, 1'b0);
    pop_one;

    // Undefined funct3 resolves not-taken; predicted taken -> mispredict
    set_beat(OP_BR, 3'b010, 5'd11, 32'h600, 32'h10, 32'h5, 32'h5, 1'b1, 32'h610);
    push_one;
    chk_head("undef", 5'd11, 32'h0, 1'b0, 32'h610, 32'h604, 1'b1);
    pop_one;
    chk("undef.cnt_res", 64'(cnt_resolved), 64'd10);
    chk("undef.cnt_mis", 64'(cnt_mispred), 64'd4);

    // Back-pressure: fill 4 entries
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("fill%0d.in_ready", k), 64'(in_ready), 64'd1);
      set_beat(OP_BR, 3'b000, 5'(k), 32'h400, 32'h10, 32'h7, 32'h7, 1'b1, 32'h410);
      tick;
    end
    in_valid = 1'b0;
    chk("full.in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("full.in_ready_or", 64'(in_ready), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d.rob", k), 64'(out_rob), 64'(k));
      tick;
    end
    chk("drain.empty", 64'(out_valid), 64'd0);

    // Streaming with out_ready=1 across the pointer wrap
    set_beat(OP_BR, 3'b000, 5'd5, 32'h400, 32'h10, 32'h7, 32'h7, 1'b1, 32'h410);
    tick;
    chk("stream.rob5", 64'(out_rob), 64'd5);
    in_rob = 5'd6;
    tick;
    chk("stream.rob6", 64'(out_rob), 64'd6);
    chk("stream.in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    tick;
    chk("stream.empty", 64'(out_valid), 64'd0);
    chk("stream.cnt_res_sat", 64'(cnt_resolved), 64'd15);
    chk("stream.cnt_mis", 64'(cnt_mispred), 64'd4);
    out_ready = 1'b0;

    // Flush with 3 buffered, head mispredicting, concurrent push and pop
    set_beat(OP_BR, 3'b001, 5'd20, 32'h700, 32'h10, 32'h3, 32'h3, 1'b1, 32'h710);
    tick;
    in_rob = 5'd21;
    tick;
    in_rob = 5'd22;
    tick;
    in_rob = 5'd23;
    flush = 1'b1;
    out_ready = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    chk("flush.cnt_mis", 64'(cnt_mispred), 64'd5);
    tick;
    chk("flush.no_beat", 64'(out_valid), 64'd0);

    // 17 mispredicting branches streamed: counters saturate
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      set_beat(OP_BR, 3'b001, 5'(k), 32'h800, 32'h10, 32'h1, 32'h1, 1'b1, 32'h810);
      tick;
    end
    in_valid = 1'b0;
    tick;
    chk("sat.cnt_res", 64'(cnt_resolved), 64'd15);
    chk("sat.cnt_mis", 64'(cnt_mispred), 64'd15);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    set_beat(OP_JAL, 3'd0, 5'd7, 32'h100, 32'h20, 32'd0, 32'd0, 1'b0, 32'd0);
    tick;
    tick;
    in_valid = 1'b0;
    chk("pre_rst.out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.in_ready", 64'(in_ready), 64'd1);
    chk("arst.rob", 64'(out_rob), 64'd0);
    chk("arst.rd", 64'(out_rd_data), 64'd0);
    chk("arst.next_pc", 64'(out_next_pc), 64'd0);
    chk("arst.mispred", 64'(out_mispredict), 64'd0);
    chk("arst.cnt_res", 64'(cnt_resolved), 64'd0);
    chk("arst.cnt_mis", 64'(cnt_mispred), 64'd0);
    #10;
    rst_n = 1'b1;
    tick;
    chk("post_rst.out_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
